// File: rtl/pipeline_reg.sv
// Single-stage pipeline register with synchronous flush (loads bubble value) and stall (hold).
// Optional event counters are enabled with `define PIPELINE_REG_STATS_EN.
module pipeline_reg #(
    parameter int unsigned   WIDTH = 32,
    parameter logic [1023:0] reset = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
`ifdef PIPELINE_REG_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
    output logic [31:0]      load_cnt
`endif
);

    // Bubble is the low WIDTH bits of the parameter; shorter values are zero-extended already.
    localparam logic [WIDTH-1:0] BUBBLE = reset[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = in;
        if (flush) begin
            q_d = BUBBLE;
        end else if (stall) begin
            q_d = q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign out = q_q;

`ifdef PIPELINE_REG_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] load_cnt_q,  load_cnt_d;

    // Exactly one counter advances per non-reset edge, mirroring the data priority.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        load_cnt_d  = load_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            load_cnt_d = load_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            load_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            load_cnt_q  <= load_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign load_cnt  = load_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_reg.sv
// Directed-vector bench for pipeline_reg (WIDTH=32, bubble=3), including optional counters.
`timescale 1ns/1ps
module tb_pipeline_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] in;
    logic [31:0] out;
`ifdef PIPELINE_REG_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, load_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_reg #(
        .WIDTH (32),
        .reset (1024'd3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .stall (stall),
        .in    (in),
        .out   (out)
`ifdef PIPELINE_REG_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .load_cnt  (load_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one posedge, then settle 1ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        in    = 32'h0;
        #2;
        chk("reset_state", out, 32'd3);
        step();
        chk("reset_held", out, 32'd3);
        rst = 1'b0;

        in = 32'hAA;                  step(); chk("load_aa", out, 32'hAA);
        flush = 1'b1; in = 32'h55;    step(); chk("flush", out, 32'd3);
        flush = 1'b0; in = 32'd86;    step(); chk("load_86", out, 32'd86);
        stall = 1'b1; in = 32'd5;
        #1;                                   chk("stall_no_bypass", out, 32'd86);
        step();                               chk("stall_hold", out, 32'd86);
        stall = 1'b0;                 step(); chk("release_5", out, 32'd5);
        step();                               chk("steady_5", out, 32'd5);

        in = 32'd86;                  step(); chk("reload_86", out, 32'd86);
        rst = 1'b1;
        #1;                                   chk("async_rst", out, 32'd3);
        in = 32'd7;
        step();                               chk("rst_over_edge", out, 32'd3);
        rst = 1'b0;
        #1;                                   chk("rst_release_no_load", out, 32'd3);
        step();                               chk("first_load_7", out, 32'd7);

        in = 32'h1234;                step(); chk("load_1234", out, 32'h1234);
        flush = 1'b1; stall = 1'b1; in = 32'hFFFF;
        step();                               chk("flush_over_stall", out, 32'd3);
        flush = 1'b0; stall = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            in = 32'(i);
            step();
            chk($sformatf("stream_%0d", i), out, 32'(i));
        end

        in = 32'hC0DE;                step(); chk("load_c0de", out, 32'hC0DE);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in = $urandom;
            step();
            chk($sformatf("stall5_%0d", i), out, 32'hC0DE);
        end
        stall = 1'b0; in = 32'h99;    step(); chk("stall_release", out, 32'h99);

        stall = 1'b1; in = 32'h11;
        rst = 1'b1;
        #1;                                   chk("rst_mid_stall", out, 32'd3);
        rst = 1'b0; stall = 1'b0; in = 32'h42;
        step();                               chk("post_rst_load", out, 32'h42);

`ifdef PIPELINE_REG_STATS_EN
        rst = 1'b1;
        #2;
        chk("cnt_rst_load",  load_cnt,  32'd0);
        rst = 1'b0;
        in = 32'h1; step();
        in = 32'h2; step();
        in = 32'h3; step();
        stall = 1'b1; step(); step();
        stall = 1'b0; flush = 1'b1; step();
        stall = 1'b1; step();
        stall = 1'b0; flush = 1'b0;
        chk("load_cnt",  load_cnt,  32'd3);
        chk("stall_cnt", stall_cnt, 32'd2);
        chk("flush_cnt", flush_cnt, 32'd2);
        rst = 1'b1;
        #2;
        chk("load_cnt_clr",  load_cnt,  32'd0);
        chk("stall_cnt_clr", stall_cnt, 32'd0);
        chk("flush_cnt_clr", flush_cnt, 32'd0);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
